// File: rtl/cfg_stream_loader.sv
// rtl/cfg_stream_loader.sv - framed byte-stream configuration loader with checksum-gated atomic commit
// Payload shifts into a shadow register and is copied to prog only after the trailer matches the running sum.
module cfg_stream_loader #(
  parameter int         PROG_WIDTH = 4480,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input  logic                  clb_clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic [PROG_WIDTH-1:0] prog,
  output logic                  prog_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NBYTES = PROG_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LOAD,
    S_CHECK,
    S_COMMIT
  } state_t;

  state_t                state, state_nx;
  logic [PROG_WIDTH-1:0] shadow;
  logic [CW-1:0]         count;
  logic [7:0]            sum;
  logic                  take;

  assign in_ready = (state != S_COMMIT);
  assign busy     = (state == S_LOAD) || (state == S_CHECK) || (state == S_COMMIT);
  // abort discards the byte offered in the same cycle, so it never counts as taken
  assign take     = in_valid && in_ready && !abort;

  always_ff @(posedge clb_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (take && in_data == SYNC0) state_nx = S_SYNC;
      end
      S_SYNC: begin
        if (take) begin
          if (in_data == SYNC1)      state_nx = S_LOAD;
          else if (in_data == SYNC0) state_nx = S_SYNC;
          else                       state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        if (take && count == LAST) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (take) state_nx = (in_data == sum) ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort && state != S_COMMIT) state_nx = S_IDLE;
  end

  always_ff @(posedge clb_clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      prog       <= '0;
      count      <= '0;
      sum        <= '0;
      prog_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= (state == S_COMMIT);
      case (state)
        S_SYNC: begin
          if (take && in_data == SYNC1) begin
            count <= '0;
            sum   <= '0;
          end
        end
        S_LOAD: begin
          if (take) begin
            shadow <= (shadow << 8) | PROG_WIDTH'(in_data);
            sum    <= sum + in_data;
            count  <= count + CW'(1);
          end
        end
        S_CHECK: begin
          if (take && in_data != sum) err <= 1'b1;
        end
        S_COMMIT: begin
          prog       <= shadow;
          prog_valid <= 1'b1;
          err        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb/tb_cfg_stream_loader.sv - scoreboard bench for cfg_stream_loader (32-bit and full-width instances)
// Expected commits are queued at stimulus time and popped by monitors on each done pulse.
module tb_cfg_stream_loader;

  localparam int WW = 4480;

  logic clb_clk = 1'b0;
  logic rst;
  always #5 clb_clk = ~clb_clk;

  logic [7:0]    n_data, w_data;
  logic          n_valid, w_valid, n_abort, w_abort;
  logic          n_ready, n_pv, n_busy, n_done, n_err;
  logic          w_ready, w_pv, w_busy, w_done, w_err;
  logic [31:0]   n_prog;
  logic [WW-1:0] w_prog;

  cfg_stream_loader #(.PROG_WIDTH(32)) u_narrow (
    .clb_clk(clb_clk), .rst(rst), .in_data(n_data), .in_valid(n_valid), .in_ready(n_ready),
    .abort(n_abort), .prog(n_prog), .prog_valid(n_pv), .busy(n_busy), .done(n_done), .err(n_err)
  );

  cfg_stream_loader #(.PROG_WIDTH(WW)) u_wide (
    .clb_clk(clb_clk), .rst(rst), .in_data(w_data), .in_valid(w_valid), .in_ready(w_ready),
    .abort(w_abort), .prog(w_prog), .prog_valid(w_pv), .busy(w_busy), .done(w_done), .err(w_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]   nq[$];
  logic [WW-1:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clb_clk) begin
    if (n_done) begin
      if (nq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL narrow_unexpected_done: got done=1 expected no commit");
      end else begin
        logic [31:0] e;
        e = nq.pop_front();
        chk("narrow_commit_prog", n_prog, e);
        chk("narrow_commit_prog_valid", n_pv, 1);
        chk("narrow_commit_err", n_err, 0);
      end
    end
  end

  always @(negedge clb_clk) begin
    if (w_done) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wide_unexpected_done: got done=1 expected no commit");
      end else begin
        logic [WW-1:0] e;
        e = wq.pop_front();
        n_checks++;
        if (w_prog !== e) begin
          n_fail++;
          $display("FAIL wide_commit_prog: got top %h low %h expected top %h low %h",
                   w_prog[WW-1 -: 32], w_prog[31:0], e[WW-1 -: 32], e[31:0]);
        end
        chk("wide_commit_err", w_err, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one byte, waits up to 50 cycles for in_ready; returns aligned 1ns after the accepting edge.
  task automatic send(input bit wide, input logic [7:0] b, input int maxgap);
    bit ok;
    int gap;
    ok  = 1'b0;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    repeat (gap) begin
      @(posedge clb_clk);
      #1;
    end
    if (wide) begin w_data = b; w_valid = 1'b1; end
    else      begin n_data = b; n_valid = 1'b1; end
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clb_clk);
      ok = wide ? w_ready : n_ready;
      @(posedge clb_clk);
      #1;
    end
    n_valid = 1'b0;
    w_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic send_vec(input logic [127:0] v, input int n, input int maxgap);
    for (int i = 0; i < n; i++) send(1'b0, v[8*(n-1-i) +: 8], maxgap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clb_clk);
      #1;
    end
  endtask

  initial begin
    logic [WW-1:0] wexp;
    logic [7:0]    wsum;
    logic [7:0]    bi;

    rst = 1'b1;
    n_data = '0; n_valid = 1'b0; n_abort = 1'b0;
    w_data = '0; w_valid = 1'b0; w_abort = 1'b0;
    idle(3);
    chk("reset_in_ready", n_ready, 1);
    chk("reset_prog", n_prog, 0);
    chk("reset_prog_valid", n_pv, 0);
    chk("reset_busy", n_busy, 0);
    chk("reset_done", n_done, 0);
    chk("reset_err", n_err, 0);
    rst = 1'b0;
    idle(1);

    // good frame back-to-back; in_ready low only in the COMMIT cycle
    nq.push_back(32'h11223344);
    send_vec(128'hA55A11223344AA, 7, 0);
    @(negedge clb_clk);
    chk("t1_in_ready_commit", n_ready, 0);
    chk("t1_busy_commit", n_busy, 1);
    @(negedge clb_clk);
    chk("t1_in_ready_after", n_ready, 1);
    chk("t1_done_high", n_done, 1);
    chk("t1_busy_after", n_busy, 0);
    @(negedge clb_clk);
    chk("t1_done_one_cycle", n_done, 0);
    @(posedge clb_clk);
    #1;

    // bad checksum from a fresh reset, then recovery
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send_vec(128'hA55A11223344AB, 7, 0);
    @(negedge clb_clk);
    chk("t2_err_set", n_err, 1);
    chk("t2_prog_untouched", n_prog, 0);
    chk("t2_prog_valid_low", n_pv, 0);
    chk("t2_busy_low", n_busy, 0);
    @(posedge clb_clk);
    #1;
    nq.push_back(32'h11223344);
    send_vec(128'hA55A11223344AA, 7, 0);
    idle(3);
    chk("t2_err_cleared", n_err, 0);
    chk("t2_prog_recovered", n_prog, 32'h11223344);

    // repeated SYNC0 keeps sync; broken sync loads nothing
    nq.push_back(32'h01020304);
    send_vec(128'h00A5A55A010203040A, 9, 0);
    idle(3);
    chk("t3_prog", n_prog, 32'h01020304);
    send_vec(128'hA5005A010203040A, 8, 0);
    idle(3);
    chk("t3_broken_prog", n_prog, 32'h01020304);
    chk("t3_broken_busy", n_busy, 0);

    // gaps plus abort mid-payload, then a full good frame
    send_vec(128'hA55A5566, 4, 3);
    n_abort = 1'b1;
    n_data  = 8'h77;
    n_valid = 1'b1;
    @(posedge clb_clk);
    #1;
    n_abort = 1'b0;
    n_valid = 1'b0;
    @(negedge clb_clk);
    chk("t4_busy_after_abort", n_busy, 0);
    chk("t4_err_after_abort", n_err, 0);
    chk("t4_prog_after_abort", n_prog, 32'h01020304);
    @(posedge clb_clk);
    #1;
    nq.push_back(32'hDEADBEEF);
    send_vec(128'hA55ADEADBEEF38, 7, 3);
    idle(3);
    chk("t4_prog", n_prog, 32'hDEADBEEF);
    chk("t4_prog_valid", n_pv, 1);

    // asynchronous reset between edges while loading
    send_vec(128'hA55A0102, 4, 0);
    chk("t5_busy_before", n_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_prog", n_prog, 0);
    chk("t5_prog_valid", n_pv, 0);
    chk("t5_busy", n_busy, 0);
    chk("t5_in_ready", n_ready, 1);
    chk("t5_done", n_done, 0);
    chk("t5_err", n_err, 0);
    @(negedge clb_clk);
    rst = 1'b0;
    @(posedge clb_clk);
    #1;

    // full width: byte i = i[7:0], trailer is the mod-256 sum of those bytes
    wexp = '0;
    wsum = 8'h00;
    for (int i = 0; i < WW / 8; i++) begin
      bi = i[7:0];
      wexp[WW-1-8*i -: 8] = bi;
      wsum = wsum + bi;
    end
    chk("t6_trailer_value", wsum, 8'h68);
    wq.push_back(wexp);
    send(1'b1, 8'hA5, 0);
    send(1'b1, 8'h5A, 0);
    for (int i = 0; i < WW / 8; i++) begin
      bi = i[7:0];
      send(1'b1, bi, 0);
    end
    send(1'b1, wsum, 0);
    idle(3);
    chk("t6_top_byte", w_prog[WW-1 -: 8], 8'h00);
    chk("t6_low_byte", w_prog[7:0], 8'h2F);
    chk("t6_prog_valid", w_pv, 1);
    chk("t6_busy", w_busy, 0);

    idle(3);
    chk("narrow_queue_drained", nq.size(), 0);
    chk("wide_queue_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
